// File: rtl/fpu_round_pack_if.sv
// rtl/fpu_round_pack_if.sv - operand/result handshake bundle for the FP round-and-pack stage
interface fpu_round_pack_if #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 24
);
  logic                    i_valid;
  logic                    o_ready;
  logic                    i_sign;
  logic [EXP_W-1:0]        i_exp;
  logic [MANT_W-1:0]       i_mant;
  logic                    i_guard;
  logic                    i_round;
  logic                    i_sticky;
  logic [1:0]              i_rnd_mode;
  logic                    i_is_nan;
  logic                    i_is_inf;
  logic                    i_is_zero;
  logic                    o_valid;
  logic                    i_ready;
  logic [EXP_W+MANT_W-1:0] o_result;
  logic                    o_inexact;
  logic                    o_overflow;

  modport slave (
    input  i_valid, i_sign, i_exp, i_mant, i_guard, i_round, i_sticky,
           i_rnd_mode, i_is_nan, i_is_inf, i_is_zero, i_ready,
    output o_ready, o_valid, o_result, o_inexact, o_overflow
  );

  modport master (
    output i_valid, i_sign, i_exp, i_mant, i_guard, i_round, i_sticky,
           i_rnd_mode, i_is_nan, i_is_inf, i_is_zero, i_ready,
    input  o_ready, o_valid, o_result, o_inexact, o_overflow
  );
endinterface

// File: rtl/fpu_round_pack.sv
// rtl/fpu_round_pack.sv - two-stage round-increment decide / apply-and-pack for the FP add path
module fpu_round_pack #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 24
) (
  input  logic i_clk,
  input  logic i_rst,
  fpu_round_pack_if.slave bus
);
  localparam int RES_W = EXP_W + MANT_W;

  logic s1_load, s2_load;
  logic v1, v2;

  logic              s1_sign, s1_inc, s1_inexact, s1_nan, s1_inf, s1_zero;
  logic [EXP_W-1:0]  s1_exp;
  logic [MANT_W-1:0] s1_mant;

  logic [RES_W-1:0]  res_q;
  logic              inexact_q, overflow_q;

  assign s2_load      = !v2 || bus.i_ready;
  assign s1_load      = !v1 || s2_load;
  assign bus.o_ready  = s1_load;
  assign bus.o_valid  = v2;
  assign bus.o_result = res_q;
  assign bus.o_inexact  = inexact_q;
  assign bus.o_overflow = overflow_q;

  logic lsbs, special, inc_d;

  always_comb begin
    lsbs    = bus.i_guard | bus.i_round | bus.i_sticky;
    special = bus.i_is_nan | bus.i_is_inf | bus.i_is_zero;
    inc_d   = 1'b0;
    case (bus.i_rnd_mode)
      2'b00:   inc_d = bus.i_guard & (bus.i_round | bus.i_sticky | bus.i_mant[0]);
      2'b01:   inc_d = 1'b0;
      2'b10:   inc_d = !bus.i_sign & lsbs;
      default: inc_d = bus.i_sign & lsbs;
    endcase
    if (special) inc_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1 <= 1'b0;
    end else if (s1_load) begin
      v1 <= bus.i_valid;
      if (bus.i_valid) begin
        s1_sign    <= bus.i_sign;
        s1_exp     <= bus.i_exp;
        s1_mant    <= bus.i_mant;
        s1_inc     <= inc_d;
        s1_inexact <= lsbs & !special;
        s1_nan     <= bus.i_is_nan;
        s1_inf     <= bus.i_is_inf;
        s1_zero    <= bus.i_is_zero;
      end
    end
  end

  // Bit k flips only when the increment ripples through an all-ones prefix below it.
  function automatic logic [MANT_W:0] prefix_inc(input logic [MANT_W-1:0] mant, input logic inc);
    logic [MANT_W:0] out;
    logic            carry;
    carry = inc;
    for (int k = 0; k < MANT_W; k++) begin
      out[k] = mant[k] ^ carry;
      carry  = carry & mant[k];
    end
    out[MANT_W] = carry;
    return out;
  endfunction

  logic [MANT_W:0]   sum;
  logic [MANT_W-1:0] m_r;
  logic [EXP_W-1:0]  e_r;
  logic [RES_W-1:0]  res_d;
  logic              inexact_d, overflow_d;

  always_comb begin
    sum = prefix_inc(s1_mant, s1_inc);
    m_r = sum[MANT_W-1:0];
    e_r = s1_exp;
    if (sum[MANT_W]) begin
      m_r = {1'b1, {(MANT_W-1){1'b0}}};
      e_r = s1_exp + EXP_W'(1);
    end else if (s1_exp == '0 && sum[MANT_W-1]) begin
      e_r = EXP_W'(1);
    end

    res_d      = {s1_sign, e_r, m_r[MANT_W-2:0]};
    inexact_d  = s1_inexact;
    overflow_d = 1'b0;
    if (s1_nan) begin
      res_d     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-2){1'b0}}};
      inexact_d = 1'b0;
    end else if (s1_inf) begin
      res_d     = {s1_sign, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
      inexact_d = 1'b0;
    end else if (s1_zero) begin
      res_d     = {s1_sign, {(RES_W-1){1'b0}}};
      inexact_d = 1'b0;
    end else if (e_r == {EXP_W{1'b1}}) begin
      res_d      = {s1_sign, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
      inexact_d  = 1'b1;
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v2         <= 1'b0;
      res_q      <= '0;
      inexact_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else if (s2_load) begin
      v2 <= v1;
      if (v1) begin
        res_q      <= res_d;
        inexact_q  <= inexact_d;
        overflow_q <= overflow_d;
      end
    end
  end
endmodule

// File: tb/tb_fpu_round_pack.sv
// tb/tb_fpu_round_pack.sv - directed and randomized checks of fpu_round_pack against an arithmetic model
module tb_fpu_round_pack;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpu_round_pack_if #(.EXP_W(8), .MANT_W(24)) bus ();

  fpu_round_pack #(.EXP_W(8), .MANT_W(24)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic        sign;
    logic [7:0]  ex;
    logic [23:0] mant;
    logic        g, r, s;
    logic [1:0]  mode;
    logic        nan, inf, zero;
  } op_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [33:0] sb[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference: exact value is mant + grs/8 ulp; pick rounded integer, then renormalize.
  function automatic logic [33:0] model(input op_t o);
    int rem, m, e;
    logic up;
    logic [31:0] mv, ev;
    if (o.nan)  return {2'b00, 32'h7FC00000};
    if (o.inf)  return {2'b00, o.sign, 8'hFF, 23'h0};
    if (o.zero) return {2'b00, o.sign, 31'h0};
    rem = int'(o.g) * 4 + int'(o.r) * 2 + int'(o.s);
    m = int'(o.mant);
    case (o.mode)
      2'd0:    up = (rem > 4) || (rem == 4 && (m % 2) == 1);
      2'd1:    up = 1'b0;
      2'd2:    up = !o.sign && rem != 0;
      default: up = o.sign && rem != 0;
    endcase
    m = m + int'(up);
    e = int'(o.ex);
    if (m == (1 << 24)) begin
      m = m / 2;
      e = e + 1;
    end else if (e == 0 && m >= (1 << 23)) begin
      e = 1;
    end
    if (e == 255) return {2'b11, o.sign, 8'hFF, 23'h0};
    mv = m;
    ev = e;
    return {1'b0, rem != 0, o.sign, ev[7:0], mv[22:0]};
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int sel;
    o = '0;
    sel = $urandom_range(0, 15);
    o.sign = 1'($urandom);
    o.mode = 2'($urandom);
    o.g = 1'($urandom);
    o.r = 1'($urandom);
    o.s = 1'($urandom);
    if (sel == 0) o.nan = 1'b1;
    else if (sel == 1) o.inf = 1'b1;
    else if (sel == 2) o.zero = 1'b1;
    sel = $urandom_range(0, 7);
    o.ex = (sel == 0) ? 8'd254 : (sel == 1) ? 8'd0 : 8'($urandom_range(1, 253));
    if (o.ex == 0) o.mant = ($urandom_range(0, 3) == 0) ? 24'h7FFFFF : {1'b0, 23'($urandom)};
    else           o.mant = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF : {1'b1, 23'($urandom)};
    return o;
  endfunction

  task automatic drive(input op_t o);
    bus.i_sign = o.sign;  bus.i_exp = o.ex;  bus.i_mant = o.mant;
    bus.i_guard = o.g;    bus.i_round = o.r; bus.i_sticky = o.s;
    bus.i_rnd_mode = o.mode;
    bus.i_is_nan = o.nan; bus.i_is_inf = o.inf; bus.i_is_zero = o.zero;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    repeat (4) tick();
  endtask

  function automatic op_t mk(input logic sg, input logic [7:0] ex, input logic [23:0] mt,
                             input logic [2:0] grs, input logic [1:0] md, input logic [2:0] sp);
    op_t o;
    o.sign = sg; o.ex = ex; o.mant = mt;
    {o.g, o.r, o.s} = grs;
    o.mode = md;
    {o.nan, o.inf, o.zero} = sp;
    return o;
  endfunction

  task automatic run_vec(input string tag, input op_t o, input logic [31:0] er,
                         input logic ei, input logic eo);
    int lat;
    tick();
    drive(o);
    bus.i_valid = 1'b1;
    bus.i_ready = 1'b1;
    @(negedge clk);
    check({tag, "_accept"}, 32'(bus.o_ready), 32'd1);
    tick();
    bus.i_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.o_valid && lat < 8) begin
      lat++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 32'(lat), 32'd2);
    check({tag, "_result"}, bus.o_result, er);
    check({tag, "_inexact"}, 32'(bus.o_inexact), 32'(ei));
    check({tag, "_overflow"}, 32'(bus.o_overflow), 32'(eo));
  endtask

  initial begin
    op_t ops[4];
    logic [33:0] bp_exp[4];
    logic [33:0] e;
    logic [31:0] prev_res;
    logic prev_stall;
    int idx, got, cyc;

    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    drive('0);
    @(posedge clk);
    @(negedge clk);
    check("reset_o_valid", 32'(bus.o_valid), 32'd0);
    check("reset_o_result", bus.o_result, 32'd0);
    check("reset_o_ready", 32'(bus.o_ready), 32'd1);
    check("reset_flags", {30'd0, bus.o_inexact, bus.o_overflow}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    run_vec("rne_tie_odd",  mk(0, 127, 24'h800001, 3'b100, 2'd0, 3'b000), 32'h3F800002, 1, 0);
    run_vec("rne_tie_even", mk(0, 127, 24'h800000, 3'b100, 2'd0, 3'b000), 32'h3F800000, 1, 0);
    run_vec("carry_renorm", mk(0, 127, 24'hFFFFFF, 3'b110, 2'd0, 3'b000), 32'h40000000, 1, 0);
    run_vec("ovf_rup",      mk(0, 254, 24'hFFFFFF, 3'b100, 2'd2, 3'b000), 32'h7F800000, 1, 1);
    run_vec("ovf_rtz",      mk(0, 254, 24'hFFFFFF, 3'b100, 2'd1, 3'b000), 32'h7F7FFFFF, 1, 0);
    run_vec("ovf_rdn_neg",  mk(1, 254, 24'hFFFFFF, 3'b100, 2'd3, 3'b000), 32'hFF800000, 1, 1);
    run_vec("subn_promote", mk(0, 0,   24'h7FFFFF, 3'b110, 2'd0, 3'b000), 32'h00800000, 1, 0);
    run_vec("nan",          mk(1, 255, 24'h123456, 3'b111, 2'd2, 3'b100), 32'h7FC00000, 0, 0);
    run_vec("inf_neg",      mk(1, 255, 24'h0,      3'b111, 2'd3, 3'b010), 32'hFF800000, 0, 0);
    run_vec("zero_neg",     mk(1, 0,   24'h0,      3'b101, 2'd3, 3'b001), 32'h80000000, 0, 0);
    drain();

    // Backpressure: downstream stalled for four cycles while four operands are offered.
    for (int i = 0; i < 4; i++) begin
      ops[i] = mk(1'($urandom), 8'($urandom_range(1, 200)), {1'b1, 23'($urandom)},
                  3'($urandom), 2'($urandom), 3'b000);
      bp_exp[i] = model(ops[i]);
    end
    idx = 0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      bus.i_ready = 1'b0;
      bus.i_valid = 1'b1;
      drive(ops[idx]);
      @(negedge clk);
      if (c >= 3) begin
        check("bp_o_ready_low", 32'(bus.o_ready), 32'd0);
        check("bp_o_valid", 32'(bus.o_valid), 32'd1);
        check("bp_hold_result", bus.o_result, bp_exp[0][31:0]);
      end
      if (bus.i_valid && bus.o_ready) idx++;
    end
    check("bp_accepted", 32'(idx), 32'd2);
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 20) begin
      tick();
      bus.i_ready = 1'b1;
      bus.i_valid = (idx < 4);
      if (idx < 4) drive(ops[idx]);
      @(negedge clk);
      if (bus.o_valid) begin
        check($sformatf("bp_result%0d", got), bus.o_result, bp_exp[got][31:0]);
        check($sformatf("bp_flags%0d", got), {30'd0, bus.o_inexact, bus.o_overflow},
              {30'd0, bp_exp[got][32], bp_exp[got][33]});
        got++;
      end
      if (bus.i_valid && bus.o_ready) idx++;
      cyc++;
    end
    check("bp_count", 32'(got), 32'd4);
    tick();
    bus.i_valid = 1'b0;
    @(negedge clk);
    check("bp_no_dup", 32'(bus.o_valid), 32'd0);
    drain();

    // Reset with both stages occupied.
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1;
    drive(mk(0, 100, 24'hABCDEF, 3'b111, 2'd2, 3'b000));
    tick();
    drive(mk(1, 50, 24'h812345, 3'b010, 2'd0, 3'b000));
    tick();
    bus.i_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_full", 32'(bus.o_ready), 32'd0);
    tick();
    rst = 1'b0;
    bus.i_ready = 1'b1;
    @(negedge clk);
    check("midrst_o_valid", 32'(bus.o_valid), 32'd0);
    check("midrst_o_result", bus.o_result, 32'd0);
    check("midrst_o_ready", 32'(bus.o_ready), 32'd1);
    check("midrst_flags", {30'd0, bus.o_inexact, bus.o_overflow}, 32'd0);
    repeat (3) begin
      tick();
      @(negedge clk);
      check("midrst_no_output", 32'(bus.o_valid), 32'd0);
    end
    run_vec("post_rst", mk(0, 127, 24'h800001, 3'b100, 2'd0, 3'b000), 32'h3F800002, 1, 0);
    drain();

    // Randomized traffic with random backpressure, checked in order against the model.
    prev_stall = 1'b0;
    prev_res = '0;
    for (int c = 0; c < 600; c++) begin
      tick();
      bus.i_valid = ($urandom_range(0, 3) != 0);
      bus.i_ready = ($urandom_range(0, 3) != 0);
      drive(rand_op());
      @(negedge clk);
      if (prev_stall) check("rnd_stall_hold", bus.o_result, prev_res);
      if (bus.o_valid && bus.i_ready) begin
        if (sb.size() == 0) begin
          check("rnd_unexpected_output", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("rnd_result", bus.o_result, e[31:0]);
          check("rnd_flags", {30'd0, bus.o_inexact, bus.o_overflow}, {30'd0, e[32], e[33]});
        end
      end
      if (bus.i_valid && bus.o_ready)
        sb.push_back(model({bus.i_sign, bus.i_exp, bus.i_mant, bus.i_guard, bus.i_round,
                            bus.i_sticky, bus.i_rnd_mode, bus.i_is_nan, bus.i_is_inf,
                            bus.i_is_zero}));
      prev_stall = bus.o_valid && !bus.i_ready;
      prev_res = bus.o_result;
    end
    cyc = 0;
    while (sb.size() != 0 && cyc < 10) begin
      tick();
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      @(negedge clk);
      if (bus.o_valid) begin
        e = sb.pop_front();
        check("drain_result", bus.o_result, e[31:0]);
      end
      cyc++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
